// File: rtl/alu_cdb_buffer.sv
// rtl/alu_cdb_buffer.sv - collapsing result queue between the ALU and the CDB arbiter
// Holds finished ALU results, squashes/updates them on branch resolution, and presents the oldest to the CDB.
module alu_cdb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_done,
  input  logic [5:0]  alu_tagDest,
  input  logic [63:0] alu_result,
  input  logic [3:0]  alu_bmask,
  input  logic        br_fub_done,
  input  logic        br_fub_pred_wrong,
  input  logic [1:0]  br_fub_bs_ptr,
  input  logic        cdb_grant,
  output logic        buf_req,
  output logic [5:0]  buf_tagDest,
  output logic [63:0] buf_result,
  output logic [3:0]  buf_bmask,
  output logic        buf_full,
  output logic        buf_overflow
);

  logic        valid_q  [DEPTH];
  logic [5:0]  tag_q    [DEPTH];
  logic [63:0] result_q [DEPTH];
  logic [3:0]  bmask_q  [DEPTH];
  logic        full_q;
  logic        ovf_q;

  logic        valid_n  [DEPTH];
  logic [5:0]  tag_n    [DEPTH];
  logic [63:0] result_n [DEPTH];
  logic [3:0]  bmask_n  [DEPTH];
  logic        full_n;
  logic        ovf_set;

  logic        squash;
  logic        resolve;
  logic [3:0]  clr_mask;
  logic        head_taken;
  logic        in_squash;
  logic        accept;
  logic        surv [DEPTH];
  int          rank [DEPTH];
  int          cnt;

  assign squash     = br_fub_done && br_fub_pred_wrong;
  assign resolve    = br_fub_done && !br_fub_pred_wrong;
  assign clr_mask   = resolve ? (4'b0001 << br_fub_bs_ptr) : 4'b0000;
  assign in_squash  = squash && alu_bmask[br_fub_bs_ptr];

  // A head being squashed this cycle must not win the CDB.
  assign buf_req     = valid_q[0] && !(squash && bmask_q[0][br_fub_bs_ptr]);
  assign head_taken  = buf_req && cdb_grant;
  assign buf_tagDest = tag_q[0];
  assign buf_result  = result_q[0];
  assign buf_bmask   = bmask_q[0] & ~clr_mask;
  assign buf_full    = full_q;
  assign buf_overflow = ovf_q;

  always_comb begin
    cnt     = 0;
    accept  = 1'b0;
    ovf_set = 1'b0;
    full_n  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_n[i]  = 1'b0;
      tag_n[i]    = '0;
      result_n[i] = '0;
      bmask_n[i]  = '0;
      surv[i]     = valid_q[i] && !(squash && bmask_q[i][br_fub_bs_ptr]) && !((i == 0) && head_taken);
      rank[i]     = cnt;
      if (surv[i]) cnt = cnt + 1;
    end
    // Survivors slide down to their rank; the arriving result lands right behind them.
    for (int j = 0; j < DEPTH; j++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (surv[i] && rank[i] == j) begin
          valid_n[j]  = 1'b1;
          tag_n[j]    = tag_q[i];
          result_n[j] = result_q[i];
          bmask_n[j]  = bmask_q[i] & ~clr_mask;
        end
      end
    end
    accept  = alu_done && !in_squash && (cnt < DEPTH);
    ovf_set = alu_done && (cnt == DEPTH);
    for (int j = 0; j < DEPTH; j++) begin
      if (accept && cnt == j) begin
        valid_n[j]  = 1'b1;
        tag_n[j]    = alu_tagDest;
        result_n[j] = alu_result;
        bmask_n[j]  = alu_bmask & ~clr_mask;
      end
    end
    full_n = (cnt + (accept ? 1 : 0)) >= DEPTH - 1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        result_q[i] <= '0;
        bmask_q[i]  <= '0;
      end
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= valid_n[i];
        tag_q[i]    <= tag_n[i];
        result_q[i] <= result_n[i];
        bmask_q[i]  <= bmask_n[i];
      end
      full_q <= full_n;
      ovf_q  <= ovf_q | ovf_set;
    end
  end

endmodule

// File: tb/tb_alu_cdb_buffer.sv
// tb/tb_alu_cdb_buffer.sv - directed and randomized bench for alu_cdb_buffer against a queue model
module tb_alu_cdb_buffer;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_done = 1'b0;
  logic [5:0]  alu_tagDest = '0;
  logic [63:0] alu_result = '0;
  logic [3:0]  alu_bmask = '0;
  logic        br_fub_done = 1'b0;
  logic        br_fub_pred_wrong = 1'b0;
  logic [1:0]  br_fub_bs_ptr = '0;
  logic        cdb_grant = 1'b0;
  logic        buf_req;
  logic [5:0]  buf_tagDest;
  logic [63:0] buf_result;
  logic [3:0]  buf_bmask;
  logic        buf_full;
  logic        buf_overflow;

  alu_cdb_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_done(alu_done), .alu_tagDest(alu_tagDest), .alu_result(alu_result), .alu_bmask(alu_bmask),
    .br_fub_done(br_fub_done), .br_fub_pred_wrong(br_fub_pred_wrong), .br_fub_bs_ptr(br_fub_bs_ptr),
    .cdb_grant(cdb_grant),
    .buf_req(buf_req), .buf_tagDest(buf_tagDest), .buf_result(buf_result), .buf_bmask(buf_bmask),
    .buf_full(buf_full), .buf_overflow(buf_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  tag;
    logic [63:0] result;
    logic [3:0]  bmask;
  } ent_t;

  ent_t q[$];
  bit   m_full;
  bit   m_ovf;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input bit done, input logic [5:0] tag, input logic [63:0] res, input logic [3:0] bm,
                       input bit bd, input bit bw, input logic [1:0] ptr, input bit grant);
    alu_done = done; alu_tagDest = tag; alu_result = res; alu_bmask = bm;
    br_fub_done = bd; br_fub_pred_wrong = bw; br_fub_bs_ptr = ptr; cdb_grant = grant;
  endtask

  // Check this cycle's outputs against the model, then advance the model across the edge.
  task automatic step();
    ent_t nq[$];
    ent_t e;
    bit sq, rs, req;
    logic [3:0] rm;
    @(negedge clock);
    sq  = br_fub_done && br_fub_pred_wrong;
    rs  = br_fub_done && !br_fub_pred_wrong;
    rm  = rs ? (4'b0001 << br_fub_bs_ptr) : 4'b0000;
    req = (q.size() > 0) && !(sq && q[0].bmask[br_fub_bs_ptr]);
    check("buf_req", buf_req, req);
    if (q.size() > 0) begin
      check("buf_tagDest", buf_tagDest, q[0].tag);
      check("buf_result", buf_result, q[0].result);
      check("buf_bmask", buf_bmask, q[0].bmask & ~rm);
    end
    check("buf_full", buf_full, m_full);
    check("buf_overflow", buf_overflow, m_ovf);
    for (int i = 0; i < q.size(); i++) begin
      if (i == 0 && req && cdb_grant) continue;
      if (sq && q[i].bmask[br_fub_bs_ptr]) continue;
      e = q[i];
      e.bmask = e.bmask & ~rm;
      nq.push_back(e);
    end
    if (alu_done && nq.size() == DEPTH) m_ovf = 1'b1;
    if (alu_done && !(sq && alu_bmask[br_fub_bs_ptr]) && nq.size() < DEPTH) begin
      e.tag = alu_tagDest; e.result = alu_result; e.bmask = alu_bmask & ~rm;
      nq.push_back(e);
    end
    m_full = nq.size() >= DEPTH - 1;
    q = nq;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input bit grant);
    drive(0, 0, 0, 0, 0, 0, 0, grant);
    step();
  endtask

  initial begin
    #1;
    check("reset_req", buf_req, 0);
    check("reset_full", buf_full, 0);
    check("reset_ovf", buf_overflow, 0);
    check("reset_tag", buf_tagDest, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // single result with constant grant
    drive(1, 19, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0000, 0, 0, 0, 1);
    step();
    idle(1);
    idle(1);

    // backpressure then drain in order
    drive(1, 9, 64'd900, 0, 0, 0, 0, 0); step();
    drive(1, 19, 64'd1900, 0, 0, 0, 0, 0); step();
    drive(1, 20, 64'd2000, 0, 0, 0, 0, 0); step();
    check("full_after_three", buf_full, 1);
    drive(1, 21, 64'd2100, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 5; i++) idle(1);

    // squash leaving a hole
    drive(1, 5, 64'd5, 4'b0001, 0, 0, 0, 0); step();
    drive(1, 6, 64'd6, 4'b0000, 0, 0, 0, 0); step();
    drive(1, 7, 64'd7, 4'b0011, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 1, 0, 0); step();
    check("hole_tag6", buf_tagDest, 6);
    idle(0);
    idle(1);

    // correct resolve clears the mask bit
    drive(1, 3, 64'd3, 4'b0100, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 0, 2, 0); step();
    idle(0);
    idle(1);

    // same-cycle squash of head and incoming
    drive(1, 8, 64'd8, 4'b1000, 0, 0, 0, 0); step();
    drive(1, 10, 64'd10, 4'b1000, 1, 1, 3, 1); step();
    idle(1);

    // reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'(30 + i), 64'(i), 0, 0, 0, 0, 0); step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check("midreset_req", buf_req, 0);
    check("midreset_full", buf_full, 0);
    check("midreset_tag", buf_tagDest, 0);
    check("midreset_result", buf_result, 0);
    q.delete();
    m_full = 1'b0;
    m_ovf = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    drive(1, 44, 64'hDEAD_BEEF, 0, 0, 0, 0, 0); step();
    idle(1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(99) < 60, 6'($urandom), {$urandom, $urandom}, 4'($urandom),
            $urandom_range(99) < 20, $urandom_range(1) == 1, 2'($urandom_range(3)),
            $urandom_range(99) < 45);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
